// File: rtl/parser_typedefs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parser_typedefs_pkg
//  Description : Shared types for the parser PHS stream and the flow table.
//  Revision    : 1.0  initial release
// ============================================================================
package parser_typedefs_pkg;

    localparam int PHS_WIDTH      = 120;
    localparam int FLOW_KEY_W     = 104;
    localparam int FLOW_CNT_MAX_W = 32;

    typedef struct packed {
        logic [7:0]  tag;
        logic [7:0]  tos;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [7:0]  proto;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } PHS_Struct;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [7:0]  proto;
        logic [15:0] sport;
        logic [15:0] dport;
    } FlowKey;

    typedef struct packed {
        logic                      valid;
        FlowKey                    key;
        logic [FLOW_CNT_MAX_W-1:0] count;
        logic [31:0]               last_seen;
    } FlowEntry;

    typedef enum logic [1:0] {
        FT_IDLE   = 2'd0,
        FT_LOOKUP = 2'd1,
        FT_UPDATE = 2'd2,
        FT_OUTPUT = 2'd3
    } FT_STATES;

endpackage
`default_nettype wire

// File: rtl/phs_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : phs_fifo
//  Description : Synchronous FIFO; a push into a full FIFO is accepted when a
//                pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module phs_fifo #(
    parameter int WIDTH = 120,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Power-of-two depth: pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/phs_flow_table.sv
`default_nettype none
// ============================================================================
//  Module      : phs_flow_table
//  Description : Buffers parser PHS words, looks up the 5-tuple in a fully
//                associative flow table and emits {id, new, count, TOS}.
//                Define FLOW_AGING_EN to expire idle entries after AGE_LIMIT.
//  Revision    : 1.0  initial release
// ============================================================================
module phs_flow_table
    import parser_typedefs_pkg::*;
#(
    parameter int FLOW_ENTRIES = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 16,
    parameter int AGE_LIMIT    = 1024
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic [PHS_WIDTH-1:0]            phs_i,
    input  logic                            phs_valid_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [$clog2(FLOW_ENTRIES)-1:0] flow_id_o,
    output logic                            flow_new_o,
    output logic [CNT_W-1:0]                pkt_cnt_o,
    output logic [7:0]                      tos_o,
    output logic [15:0]                     drop_cnt_o
);

    localparam int               c_IDX_W   = $clog2(FLOW_ENTRIES);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    PHS_Struct          w_fifo_phs;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_unused;

    FT_STATES           r_state;
    FT_STATES           w_state_nxt;

    FlowKey             r_key;
    logic [7:0]         r_tos;
    logic [15:0]        r_drop_cnt;

    logic [FLOW_ENTRIES-1:0] r_valid;
    FlowKey                  r_tab_key [FLOW_ENTRIES];
    logic [CNT_W-1:0]        r_tab_cnt [FLOW_ENTRIES];
    logic [FLOW_ENTRIES-1:0] w_live;

    logic               w_hit;
    logic [c_IDX_W-1:0] w_hit_idx;
    logic               w_free;
    logic [c_IDX_W-1:0] w_free_idx;
    logic               r_hit;
    logic [c_IDX_W-1:0] r_hit_idx;
    logic               r_free;
    logic [c_IDX_W-1:0] r_free_idx;
    logic [c_IDX_W-1:0] r_victim;
    logic [c_IDX_W-1:0] w_upd_idx;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_new_cnt;

    logic [c_IDX_W-1:0] r_flow_id;
    logic               r_flow_new;
    logic [CNT_W-1:0]   r_pkt_cnt;

    phs_fifo #(
        .WIDTH (PHS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (reset),
        .i_push  (phs_valid_i),
        .i_data  (phs_i),
        .i_pop   (w_pop),
        .o_data  (w_fifo_phs),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Tag rides along in the FIFO but is not part of the flow identity
    assign w_unused = ^{w_fifo_phs.tag, 32'(AGE_LIMIT)};

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (phs_valid_i && w_fifo_full && !w_pop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= FT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            FT_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = FT_LOOKUP;
                end
            end
            FT_LOOKUP: w_state_nxt = FT_UPDATE;
            FT_UPDATE: w_state_nxt = FT_OUTPUT;
            FT_OUTPUT: begin
                if (out_ready_i) begin
                    w_state_nxt = FT_IDLE;
                end
            end
            default:   w_state_nxt = FT_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_key <= '0;
            r_tos <= '0;
        end else if (w_pop) begin
            r_key <= {w_fifo_phs.src_ip, w_fifo_phs.dst_ip, w_fifo_phs.proto,
                      w_fifo_phs.sport, w_fifo_phs.dport};
            r_tos <= w_fifo_phs.tos;
        end
    end

`ifdef FLOW_AGING_EN
    logic [31:0] r_now;
    logic [31:0] r_tab_seen [FLOW_ENTRIES];

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_now <= '0;
        end else begin
            r_now <= r_now + 32'd1;
        end
    end

    // Modulo-2^32 age keeps working across timestamp wrap
    always_comb begin
        w_live = '0;
        for (int i = 0; i < FLOW_ENTRIES; i++) begin
            w_live[i] = r_valid[i] && ((r_now - r_tab_seen[i]) <= 32'(AGE_LIMIT));
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == FT_UPDATE) begin
            r_tab_seen[w_upd_idx] <= r_now;
        end
    end
`else
    assign w_live = r_valid;
`endif

    // Descending scan so the lowest matching / free index wins
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = FLOW_ENTRIES - 1; i >= 0; i--) begin
            if (w_live[i] && (r_tab_key[i] == r_key)) begin
                w_hit     = 1'b1;
                w_hit_idx = c_IDX_W'(i);
            end
            if (!w_live[i]) begin
                w_free     = 1'b1;
                w_free_idx = c_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_free     <= 1'b0;
            r_free_idx <= '0;
        end else if (r_state == FT_LOOKUP) begin
            r_hit      <= w_hit;
            r_hit_idx  <= w_hit_idx;
            r_free     <= w_free;
            r_free_idx <= w_free_idx;
        end
    end

    assign w_upd_idx = r_hit  ? r_hit_idx  :
                       r_free ? r_free_idx : r_victim;
    assign w_cnt_inc = (r_tab_cnt[r_hit_idx] == c_CNT_MAX) ? c_CNT_MAX
                                                           : r_tab_cnt[r_hit_idx] + c_CNT_ONE;
    assign w_new_cnt = r_hit ? w_cnt_inc : c_CNT_ONE;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_valid    <= '0;
            r_victim   <= '0;
            r_flow_id  <= '0;
            r_flow_new <= 1'b0;
            r_pkt_cnt  <= '0;
        end else if (r_state == FT_UPDATE) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_flow_id          <= w_upd_idx;
            r_flow_new         <= !r_hit;
            r_pkt_cnt          <= w_new_cnt;
            if (!r_hit && !r_free) begin
                r_victim <= r_victim + c_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == FT_UPDATE) begin
            r_tab_key[w_upd_idx] <= r_key;
            r_tab_cnt[w_upd_idx] <= w_new_cnt;
        end
    end

    assign out_valid_o = (r_state == FT_OUTPUT);
    assign flow_id_o   = r_flow_id;
    assign flow_new_o  = r_flow_new;
    assign pkt_cnt_o   = r_pkt_cnt;
    assign tos_o       = r_tos;
    assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_phs_flow_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phs_flow_table
//  Description : Directed self-checking bench for phs_flow_table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_phs_flow_table;

    localparam int FLOW_ENTRIES = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int CNT_W        = 16;
    localparam int AGE_LIMIT    = 16;

    logic         CLK = 1'b0;
    logic         reset;
    logic [119:0] phs_i;
    logic         phs_valid_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [2:0]   flow_id_o;
    logic         flow_new_o;
    logic [15:0]  pkt_cnt_o;
    logic [7:0]   tos_o;
    logic [15:0]  drop_cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK = ~CLK;

    phs_flow_table #(
        .FLOW_ENTRIES (FLOW_ENTRIES),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CNT_W        (CNT_W),
        .AGE_LIMIT    (AGE_LIMIT)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .phs_i       (phs_i),
        .phs_valid_i (phs_valid_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .flow_id_o   (flow_id_o),
        .flow_new_o  (flow_new_o),
        .pkt_cnt_o   (pkt_cnt_o),
        .tos_o       (tos_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Flows differ by source port; tag is varied to show it is ignored
    function automatic logic [119:0] mk(input logic [15:0] sport, input logic [7:0] tos,
                                        input logic [7:0] tag);
        return {tag, tos, sport, 16'd80, 8'd17, 32'h0A00_0001, 32'h0A00_0002};
    endfunction

    task automatic send(input logic [119:0] p);
        @(negedge CLK);
        phs_i       = p;
        phs_valid_i = 1'b1;
        @(negedge CLK);
        phs_valid_i = 1'b0;
    endtask

    task automatic expect_res(input string tag, input int id, input bit nw, input int cnt,
                              input logic [7:0] tos, output int lat);
        lat = 0;
        while (!out_valid_o && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        chk({tag, ".valid"}, 64'(out_valid_o), 64'(1));
        chk({tag, ".id"},    64'(flow_id_o),   64'(id));
        chk({tag, ".new"},   64'(flow_new_o),  64'(nw));
        chk({tag, ".cnt"},   64'(pkt_cnt_o),   64'(cnt));
        chk({tag, ".tos"},   64'(tos_o),       64'(tos));
        @(negedge CLK);
        chk({tag, ".vdrop"}, 64'(out_valid_o), 64'(0));
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        logic [119:0] burst [6];

        reset       = 1'b1;
        phs_valid_i = 1'b0;
        phs_i       = '0;
        out_ready_i = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst.valid", 64'(out_valid_o), 64'(0));
        chk("rst.id",    64'(flow_id_o),   64'(0));
        chk("rst.new",   64'(flow_new_o),  64'(0));
        chk("rst.cnt",   64'(pkt_cnt_o),   64'(0));
        chk("rst.tos",   64'(tos_o),       64'(0));
        chk("rst.drop",  64'(drop_cnt_o),  64'(0));
        reset = 1'b0;

        // Single flow, then the same 5-tuple twice more with new TOS/tag
        send(mk(16'd1000, 8'h10, 8'h01));
        expect_res("t1", 0, 1'b1, 1, 8'h10, lat);
        chk("t1.lat", 64'(lat), 64'(3));
        send(mk(16'd1000, 8'h20, 8'h02));
        expect_res("t2a", 0, 1'b0, 2, 8'h20, lat);
        send(mk(16'd1000, 8'h30, 8'h03));
        expect_res("t2b", 0, 1'b0, 3, 8'h30, lat);

        // Fill the table, then force round-robin eviction
        for (int f = 1; f < 8; f++) begin
            send(mk(16'(1000 + f), 8'(f), 8'h55));
            expect_res($sformatf("t3.f%0d", f), f, 1'b1, 1, 8'(f), lat);
        end
        send(mk(16'd1008, 8'h08, 8'h55));
        expect_res("t3.evict", 0, 1'b1, 1, 8'h08, lat);
        send(mk(16'd1000, 8'h44, 8'h66));
        expect_res("t3.reins", 1, 1'b1, 1, 8'h44, lat);
        send(mk(16'd1008, 8'h09, 8'h77));
        expect_res("t3.hit8", 0, 1'b0, 2, 8'h09, lat);

        // Burst of six with downstream stalled: one dropped
        pulse_reset();
        out_ready_i = 1'b0;
        burst[0] = mk(16'd2000, 8'hB1, 8'h00);
        burst[1] = mk(16'd2000, 8'hB2, 8'h01);
        burst[2] = mk(16'd2001, 8'hB3, 8'h02);
        burst[3] = mk(16'd2000, 8'hB4, 8'h03);
        burst[4] = mk(16'd2002, 8'hB5, 8'h04);
        burst[5] = mk(16'd2003, 8'hB6, 8'h05);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            phs_i       = burst[i];
            phs_valid_i = 1'b1;
        end
        @(negedge CLK);
        phs_valid_i = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t4.drop",  64'(drop_cnt_o),  64'(1));
        chk("t4.valid", 64'(out_valid_o), 64'(1));
        chk("t4.tos",   64'(tos_o),       64'(8'hB1));
        repeat (4) @(negedge CLK);
        chk("t4.hold_valid", 64'(out_valid_o), 64'(1));
        chk("t4.hold_tos",   64'(tos_o),       64'(8'hB1));
        chk("t4.hold_cnt",   64'(pkt_cnt_o),   64'(1));
        out_ready_i = 1'b1;
        expect_res("t4.r0", 0, 1'b1, 1, 8'hB1, lat);
        expect_res("t4.r1", 0, 1'b0, 2, 8'hB2, lat);
        expect_res("t4.r2", 1, 1'b1, 1, 8'hB3, lat);
        expect_res("t4.r3", 0, 1'b0, 3, 8'hB4, lat);
        expect_res("t4.r4", 2, 1'b1, 1, 8'hB5, lat);
        repeat (10) @(negedge CLK);
        chk("t4.empty", 64'(out_valid_o), 64'(0));
        chk("t4.drop2", 64'(drop_cnt_o),  64'(1));

        // Reset while a result is waiting in OUTPUT
        out_ready_i = 1'b0;
        send(mk(16'd2001, 8'hC5, 8'h10));
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        chk("t5.valid", 64'(out_valid_o), 64'(1));
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        chk("t5.rst_valid", 64'(out_valid_o), 64'(0));
        chk("t5.rst_drop",  64'(drop_cnt_o),  64'(0));
        out_ready_i = 1'b1;
        send(mk(16'd2001, 8'hC6, 8'h11));
        expect_res("t5.resend", 0, 1'b1, 1, 8'hC6, lat);

`ifdef FLOW_AGING_EN
        pulse_reset();
        send(mk(16'd3000, 8'h61, 8'h20));
        expect_res("t6.first", 0, 1'b1, 1, 8'h61, lat);
        repeat (20) @(negedge CLK);
        send(mk(16'd3000, 8'h62, 8'h21));
        expect_res("t6.aged", 0, 1'b1, 1, 8'h62, lat);
        repeat (10) @(negedge CLK);
        send(mk(16'd3000, 8'h63, 8'h22));
        expect_res("t6.fresh", 0, 1'b0, 2, 8'h63, lat);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phs_flow_table.md
Name: phs_flow_table

Overview:
- Downstream consumer of the N6 packet parser's PHS output (phs_o / phs_valid_o).
- Buffers each 15-byte PHS, extracts the 5-tuple and looks it up in a small fully-associative flow table.
- Assigns a flow ID and keeps a per-flow packet count.
- Presents {flow_id, new-flow flag, count, TOS} to the next stage over a valid/ready handshake. The parser cannot be stalled, so this block absorbs bursts in an input FIFO.

Parameters:
- FLOW_ENTRIES, 8, number of table entries; power of two, 2..32.
- FIFO_DEPTH, 4, input PHS FIFO depth; power of two, 2..16.
- CNT_W, 16, per-flow packet counter width.
- AGE_LIMIT, 1024, idle cycles before an entry expires (used only with FLOW_AGING_EN).

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- phs_i  in  120  PHS from parser. Fields, MSB first: [119:112] tag, [111:104] TOS, [103:88] sport, [87:72] dport, [71:64] proto, [63:32] srcIP, [31:0] dstIP.
- phs_valid_i  in  1  single-cycle strobe; no backpressure.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream ready.
- flow_id_o  out  $clog2(FLOW_ENTRIES)  table index of the flow.
- flow_new_o  out  1  flow was inserted for this packet.
- pkt_cnt_o  out  CNT_W  packet count of the flow, including this packet.
- tos_o  out  8  TOS of this packet.
- drop_cnt_o  out  16  PHS dropped on FIFO overflow; saturating.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on `reset`.
- Reset values: all outputs 0. FIFO empty. All table entries invalid. Round-robin victim pointer 0. FSM in IDLE.
- Reset mid-operation discards any in-flight result and all table contents.
- Key: 104 bits = {srcIP, dstIP, proto, sport, dport}. TOS and tag are not part of the key.
- FIFO write: on phs_valid_i when not full. If full, the PHS is dropped and drop_cnt_o increments, saturating at 0xFFFF.
- FIFO full with simultaneous pop: the pop frees a slot in the same cycle, so the push is accepted.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOOKUP, UPDATE, OUTPUT.
  - IDLE: if FIFO not empty, pop into key/TOS registers -> LOOKUP.
  - LOOKUP: compare the key against all valid entries in parallel and register hit plus hit index -> UPDATE. At most one entry can match.
  - UPDATE, hit: count = count + 1, saturating at all-ones; flow_new = 0.
  - UPDATE, miss: insert at the lowest-index invalid entry. If none is free, insert at the round-robin victim and advance the pointer, wrapping at FLOW_ENTRIES. Set count = 1, flow_new = 1. Then -> OUTPUT.
  - OUTPUT: out_valid_o = 1 and all result outputs stable. On out_valid_o && out_ready_i -> IDLE, and out_valid_o deasserts the next cycle.
- Latency: pop to out_valid_o is 3 cycles. Minimum throughput is one PHS per 4 cycles with out_ready_i held high.
- Table updates become visible to the next lookup. Back-to-back PHS of the same flow both count correctly.

Optional Feature:
- Macro: FLOW_AGING_EN.
- When defined:
  - A free-running 32-bit timestamp runs; each entry stores its last-seen timestamp, written on hit and on insert.
  - In LOOKUP, an entry with (now - last_seen) > AGE_LIMIT (modulo-2^32 subtraction) is treated as invalid. It neither matches nor blocks free-slot selection.
  - An expired flow seen again is re-inserted with flow_new_o = 1 and count 1.
- When undefined: entries persist until evicted by round-robin replacement. No timestamp logic exists.

Decomposition:
- Shared package (parser_typedefs_pkg) gets:
  - a packed PHS_Struct field view matching the layout above;
  - a FlowKey struct (104 bits);
  - a FlowEntry struct {valid, key, count, last_seen};
  - a FT_STATES enum;
  - a PHS_WIDTH = 120 constant.
- Sub-module phs_fifo: parameterised synchronous FIFO with push, pop, full and empty.
- The table and FSM stay in phs_flow_table.

Test Plan:
- Single PHS, srcIP 10.0.0.1, dstIP 10.0.0.2, proto 17, sport 1000, dport 80, TOS 0x10, ready=1 -> 3 cycles after pop: out_valid_o=1, flow_id_o=0, flow_new_o=1, pkt_cnt_o=1, tos_o=0x10.
- Same 5-tuple three times with differing TOS -> flow_id 0 each time; flow_new 1, 0, 0; pkt_cnt 1, 2, 3; tos_o tracks each packet.
- 9 distinct flows, FLOW_ENTRIES=8 -> flows 0..7 get ids 0..7. The 9th evicts id 0 (new=1). The original flow 0 resent is a miss and takes id 1.
- out_ready_i=0 while 6 PHS strobe on consecutive cycles, FIFO_DEPTH=4 -> drop_cnt_o=1 (one PHS sits in the key register). Results hold stable, then drain in order once ready=1.
- Reset asserted in OUTPUT state -> next cycle out_valid_o=0. A resent earlier flow gets flow_new_o=1, id 0.
- FLOW_AGING_EN, AGE_LIMIT=16: a flow, a 20-cycle gap, the same flow again -> flow_new_o=1, pkt_cnt_o=1. A 10-cycle gap instead -> flow_new_o=0, pkt_cnt_o=2.
